// File: rtl/bsort_pkg.sv
// rtl/bsort_pkg.sv - shared sizes, sorter state encoding and display colours
package bsort_pkg;

  localparam int N        = 6;
  localparam int W        = 8;
  localparam int TICK_DIV = 25_000_000;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    SWAP,
    DONE
  } state_t;

  // RGB565 colours shared by the bar-graph pixel generator and other display blocks
  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

endpackage

// File: rtl/bubble_sort_controller_if.sv
// rtl/bubble_sort_controller_if.sv - command and display-state bundle of the sorter
interface bubble_sort_controller_if #(
  parameter int N = bsort_pkg::N,
  parameter int W = bsort_pkg::W
) ();

  logic           start;
  logic           abort;
  logic           pause;
  logic           load;
  logic [N*W-1:0] init_flat;
  logic [N*W-1:0] array_flat;
  logic [2:0]     compare_idx1;
  logic [2:0]     compare_idx2;
  logic           swap_flag;
  logic           sorting;
  logic           done;
  logic [7:0]     swap_count;
  logic [2:0]     pass_count;

  // front end drives commands and watches the display state
  modport master (
    output start, abort, pause, load, init_flat,
    input  array_flat, compare_idx1, compare_idx2, swap_flag, sorting, done,
           swap_count, pass_count
  );

  // sorter receives commands and publishes the display state
  modport slave (
    input  start, abort, pause, load, init_flat,
    output array_flat, compare_idx1, compare_idx2, swap_flag, sorting, done,
           swap_count, pass_count
  );

endinterface

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - step pacing divider, one tick every TICK_DIV enabled cycles
module step_tick_gen #(
  parameter int TICK_DIV = bsort_pkg::TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // tick only while enabled so a paused divider never fires
  assign tick = en && (cnt == LAST);

  // divider counts while enabled, holds while paused, wraps after the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bubble_sort_controller.sv
// rtl/bubble_sort_controller.sv - paced bubble sort sequencer feeding the bar-graph display
module bubble_sort_controller #(
  parameter int N        = bsort_pkg::N,
  parameter int W        = bsort_pkg::W,
  parameter int TICK_DIV = bsort_pkg::TICK_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  bubble_sort_controller_if.slave  bus
);

  import bsort_pkg::*;

  state_t         state, state_n;
  logic [2:0]     j, j_n, j1;
  logic [2:0]     pass_cnt, pass_n;
  logic [7:0]     swaps, swaps_n;
  logic           swapped, swapped_n;
  logic [W-1:0]   arr    [N];
  logic [W-1:0]   arr_n  [N];
  logic [W-1:0]   init_arr [N];
  logic [N*W-1:0] flat;
  logic           en, clr, tick, advance;

  assign j1 = j + 3'd1;
  assign en = ((state == COMPARE) || (state == SWAP)) && !bus.pause;

  step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  // unpack the load data and pack the live array for the ports
  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) begin
      init_arr[i]       = bus.init_flat[W*i +: W];
      flat[W*i +: W]    = arr[i];
    end
  end

  assign bus.array_flat   = flat;
  assign bus.compare_idx1 = j;
  assign bus.compare_idx2 = j1;

  // command decode, compare/swap step and end-of-pass bookkeeping
  always_comb begin
    state_n   = state;
    j_n       = j;
    pass_n    = pass_cnt;
    swaps_n   = swaps;
    swapped_n = swapped;
    arr_n     = arr;
    advance   = 1'b0;
    clr       = 1'b0;

    if (bus.abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.load) begin
            arr_n   = init_arr;
            state_n = IDLE;
          end else if (bus.start) begin
            j_n       = 3'd0;
            pass_n    = 3'd0;
            swaps_n   = 8'd0;
            swapped_n = 1'b0;
            state_n   = COMPARE;
            clr       = 1'b1;
          end
        end
        COMPARE: begin
          if (tick) begin
            if (arr[j] > arr[j1]) state_n = SWAP;
            else                  advance = 1'b1;
          end
        end
        SWAP: begin
          if (tick) begin
            arr_n[j]  = arr[j1];
            arr_n[j1] = arr[j];
            swapped_n = 1'b1;
            swaps_n   = (swaps == 8'hFF) ? swaps : swaps + 8'd1;
            advance   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // the last index of a pass shrinks by one each pass as the tail settles
    if (advance) begin
      if (int'(j) < N - 2 - int'(pass_cnt)) begin
        j_n     = j1;
        state_n = COMPARE;
      end else begin
        pass_n = pass_cnt + 3'd1;
        if (!swapped_n || int'(pass_n) == N - 1) begin
          state_n = DONE;
        end else begin
          j_n       = 3'd0;
          swapped_n = 1'b0;
          state_n   = COMPARE;
        end
      end
    end
  end

  // state, array and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      j             <= 3'd0;
      pass_cnt      <= 3'd0;
      swaps         <= 8'd0;
      swapped       <= 1'b0;
      for (int i = 0; i < N; i++) arr[i] <= '0;
      bus.swap_flag <= 1'b0;
      bus.sorting   <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      j             <= j_n;
      pass_cnt      <= pass_n;
      swaps         <= swaps_n;
      swapped       <= swapped_n;
      arr           <= arr_n;
      bus.swap_flag <= (state_n == SWAP);
      bus.sorting   <= (state_n == COMPARE) || (state_n == SWAP);
      bus.done      <= (state_n == DONE);
    end
  end

  assign bus.swap_count = swaps;
  assign bus.pass_count = pass_cnt;

endmodule

// File: tb/tb_bubble_sort_controller.sv
// tb/tb_bubble_sort_controller.sv - randomized self-checking bench for the bubble sort controller
module tb_bubble_sort_controller;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int TD = 4;

  typedef logic [W-1:0] arr_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;

  bubble_sort_controller_if #(.N(N), .W(W)) bus ();

  bubble_sort_controller #(.N(N), .W(W), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [N*W-1:0] pack(input arr_t a);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[W*i +: W] = a[i];
    return r;
  endfunction

  // textbook bubble sort with early exit; lim caps the number of paced operations
  task automatic model(input arr_t a_in, input int lim, output arr_t a,
                       output int swaps, output int passes, output int ops);
    logic [W-1:0] t;
    bit stop, sw;
    a = a_in; swaps = 0; passes = 0; ops = 0; stop = 0;
    for (int p = 0; p < N - 1 && !stop; p++) begin
      sw = 0;
      for (int k = 0; k < N - 1 - p && !stop; k++) begin
        if (ops == lim) stop = 1;
        else begin
          ops++;
          if (a[k] > a[k+1]) begin
            if (ops == lim) stop = 1;
            else begin
              ops++;
              t = a[k]; a[k] = a[k+1]; a[k+1] = t;
              swaps++; sw = 1;
            end
          end
        end
      end
      if (!stop) begin
        passes++;
        if (!sw) break;
      end
    end
  endtask

  task automatic pulse_load(input arr_t a);
    @(negedge clk);
    bus.init_flat = pack(a);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    arr_t a;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) a[i] = W'($urandom_range(1, 200));
    pulse_load(a);
    pulse_start();
    repeat ($urandom_range(5, 40)) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.array_flat !== '0) $display("FAIL reset array_flat: got %h want 0", bus.array_flat); else n_pass++;
    n_total++; if (bus.compare_idx1 !== 3'd0) $display("FAIL reset compare_idx1: got %0d want 0", bus.compare_idx1); else n_pass++;
    n_total++; if (bus.compare_idx2 !== 3'd1) $display("FAIL reset compare_idx2: got %0d want 1", bus.compare_idx2); else n_pass++;
    n_total++; if (bus.swap_flag !== 1'b0) $display("FAIL reset swap_flag: got %b want 0", bus.swap_flag); else n_pass++;
    n_total++; if (bus.sorting !== 1'b0) $display("FAIL reset sorting: got %b want 0", bus.sorting); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.swap_count !== 8'd0) $display("FAIL reset swap_count: got %0d want 0", bus.swap_count); else n_pass++;
    n_total++; if (bus.pass_count !== 3'd0) $display("FAIL reset pass_count: got %0d want 0", bus.pass_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sort(input string name, input arr_t a);
    arr_t exp;
    int swaps, passes, ops, cyc;
    model(a, 1000000, exp, swaps, passes, ops);
    pulse_load(a);
    pulse_start();
    wait_done(cyc);
    n_total++; if (bus.done !== 1'b1) $display("FAIL %s done timeout: got %b after %0d cycles want 1", name, bus.done, cyc); else n_pass++;
    n_total++; if (cyc !== TD * ops) $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, TD * ops); else n_pass++;
    n_total++; if (bus.array_flat !== pack(exp)) $display("FAIL %s array: got %h want %h", name, bus.array_flat, pack(exp)); else n_pass++;
    n_total++; if (bus.swap_count !== 8'(swaps)) $display("FAIL %s swap_count: got %0d want %0d", name, bus.swap_count, swaps); else n_pass++;
    n_total++; if (bus.pass_count !== 3'(passes)) $display("FAIL %s pass_count: got %0d want %0d", name, bus.pass_count, passes); else n_pass++;
    n_total++; if (bus.sorting !== 1'b0) $display("FAIL %s sorting after done: got %b want 0", name, bus.sorting); else n_pass++;
  endtask

  task automatic test_pause();
    arr_t a, sorted;
    int cyc, bad;
    a = '{1, 0, 2, 3, 4, 5};
    sorted = '{0, 1, 2, 3, 4, 5};
    pulse_load(a);
    pulse_start();
    cyc = 0;
    while (bus.swap_flag !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (bus.swap_flag !== 1'b1) $display("FAIL pause swap entry: got %b want 1", bus.swap_flag); else n_pass++;
    bus.pause = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.swap_flag !== 1'b1 || bus.array_flat !== pack(a)) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL pause hold: got %0d disturbed cycles want 0", bad); else n_pass++;
    n_total++; if (bus.swap_count !== 8'd0) $display("FAIL pause swap_count: got %0d want 0", bus.swap_count); else n_pass++;
    bus.pause = 1'b0;
    cyc = 0;
    while (bus.swap_flag !== 1'b0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (bus.array_flat !== pack(sorted)) $display("FAIL pause release array: got %h want %h", bus.array_flat, pack(sorted)); else n_pass++;
    n_total++; if (bus.swap_count !== 8'd1) $display("FAIL pause release swap_count: got %0d want 1", bus.swap_count); else n_pass++;
    wait_done(cyc);
    n_total++; if (bus.done !== 1'b1) $display("FAIL pause done: got %b want 1", bus.done); else n_pass++;
  endtask

  task automatic test_abort();
    arr_t a, b, part;
    int swaps, passes, ops;
    a = '{9, 1, 8, 2, 7, 3};
    for (int i = 0; i < N; i++) b[i] = W'($urandom_range(0, 255));
    model(a, 3, part, swaps, passes, ops);
    pulse_load(a);
    pulse_start();
    repeat (4 * 3 + 1) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_total++; if (bus.sorting !== 1'b0) $display("FAIL abort sorting: got %b want 0", bus.sorting); else n_pass++;
    n_total++; if (bus.swap_flag !== 1'b0) $display("FAIL abort swap_flag: got %b want 0", bus.swap_flag); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL abort done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.array_flat !== pack(part)) $display("FAIL abort array: got %h want %h", bus.array_flat, pack(part)); else n_pass++;
    bus.init_flat = pack(b);
    bus.load  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    n_total++; if (bus.array_flat !== pack(b)) $display("FAIL load+start array: got %h want %h", bus.array_flat, pack(b)); else n_pass++;
    n_total++; if (bus.sorting !== 1'b0) $display("FAIL load+start sorting: got %b want 0", bus.sorting); else n_pass++;
    repeat (8) @(negedge clk);
    n_total++; if (bus.sorting !== 1'b0 || bus.array_flat !== pack(b)) $display("FAIL load+start idle: got sorting %b array %h want 0 %h", bus.sorting, bus.array_flat, pack(b)); else n_pass++;
  endtask

  initial begin
    arr_t a;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    bus.load  = 1'b0;
    bus.init_flat = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_sort("reverse", '{5, 4, 3, 2, 1, 0});
    test_sort("sorted", '{0, 1, 2, 3, 4, 5});
    test_sort("equal", '{7, 7, 3, 3, 9, 9});
    test_pause();
    test_abort();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) a[i] = W'($urandom_range(0, 15));
      test_sort($sformatf("random%0d", r), a);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
